// File: rtl/multi_mode_counter_if.sv
// rtl/multi_mode_counter_if.sv - control and status bundle for the multi-mode counter
interface multi_mode_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_wrap;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic [7:0]       wrap_cnt;

    modport master (
        output en, mode, load, load_val, clr_wrap,
        input  count, tc, wrap_cnt
    );

    modport slave (
        input  en, mode, load, load_val, clr_wrap,
        output count, tc, wrap_cnt
    );
endinterface

// File: rtl/multi_mode_counter.sv
// rtl/multi_mode_counter.sv - binary up/down, Gray and LFSR counter with wrap pulse and wrap tally
module multi_mode_counter #(
    parameter int               WIDTH     = 4,
    parameter int               MAX_VAL   = 2**WIDTH - 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(4'b1100)
) (
    input  logic                clk,
    input  logic                rst_n,
    multi_mode_counter_if.slave bus
);

    localparam logic [1:0] MODE_BIN_UP   = 2'b00;
    localparam logic [1:0] MODE_BIN_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY     = 2'b10;
    localparam logic [1:0] MODE_LFSR     = 2'b11;

    localparam logic [WIDTH-1:0] MAX_S = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_S = WIDTH'(1);
    localparam logic [7:0]       WRAP_SAT = 8'hFF;

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("multi_mode_counter: WIDTH must be within 2..16");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max_val
        $error("multi_mode_counter: MAX_VAL must be within 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic [7:0]       wrap_q;

    logic [WIDTH-1:0] step_s;
    logic             step_tc;
    logic             lfsr_fb;
    logic [WIDTH-1:0] load_s;
    logic [WIDTH-1:0] s_nxt;
    logic             tc_nxt;
    logic             advance;
    logic [WIDTH-1:0] count_nxt;
    logic [7:0]       wrap_nxt;

    // One step of the current mode's sequence, starting from whatever s holds
    always_comb begin
        step_s  = s;
        step_tc = 1'b0;
        lfsr_fb = ^(s & LFSR_TAPS);
        case (bus.mode)
            MODE_BIN_UP, MODE_GRAY: begin
                if (s >= MAX_S) begin
                    step_s  = '0;
                    step_tc = 1'b1;
                end else begin
                    step_s = s + ONE_S;
                end
            end
            MODE_BIN_DOWN: begin
                if (s == '0) begin
                    step_s  = MAX_S;
                    step_tc = 1'b1;
                end else if (s > MAX_S) begin
                    step_s = MAX_S;
                end else begin
                    step_s = s - ONE_S;
                end
            end
            default: begin
                // All-zero is the LFSR lock-up state; escape to 1 and flag it as a wrap
                if (s == '0) begin
                    step_s  = ONE_S;
                    step_tc = 1'b1;
                end else begin
                    step_s  = {s[WIDTH-2:0], lfsr_fb};
                    step_tc = ({s[WIDTH-2:0], lfsr_fb} == ONE_S);
                end
            end
        endcase
    end

    always_comb begin
        load_s = bus.load_val;
        if (bus.mode == MODE_LFSR) begin
            if (bus.load_val == '0) begin
                load_s = ONE_S;
            end
        end else if (bus.load_val > MAX_S) begin
            load_s = MAX_S;
        end
    end

    always_comb begin
        s_nxt   = s;
        tc_nxt  = 1'b0;
        advance = 1'b0;
        if (bus.load) begin
            s_nxt   = load_s;
            advance = 1'b1;
        end else if (bus.en) begin
            s_nxt   = step_s;
            tc_nxt  = step_tc;
            advance = 1'b1;
        end
    end

    // count is re-encoded only when s moves, so a mode change during hold leaves it alone
    always_comb begin
        count_nxt = count_q;
        if (advance) begin
            count_nxt = (bus.mode == MODE_GRAY) ? (s_nxt ^ (s_nxt >> 1)) : s_nxt;
        end
    end

    always_comb begin
        wrap_nxt = wrap_q;
        if (bus.clr_wrap) begin
            wrap_nxt = '0;
        end else if (tc_nxt && wrap_q != WRAP_SAT) begin
            wrap_nxt = wrap_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s       <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            wrap_q  <= '0;
        end else begin
            s       <= s_nxt;
            count_q <= count_nxt;
            tc_q    <= tc_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.wrap_cnt = wrap_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// tb/tb_multi_mode_counter.sv - directed self-checking bench for multi_mode_counter
module tb_multi_mode_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multi_mode_counter_if #(.WIDTH(4)) bus ();

    multi_mode_counter #(
        .WIDTH    (4),
        .MAX_VAL  (9),
        .LFSR_TAPS(4'b1100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int up_cnt   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int down_cnt [11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    int gray_cnt [9]  = '{1, 3, 2, 6, 7, 5, 4, 12, 13};
    int lfsr_cnt [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_count", int'(bus.count), 0);
        check("rst_async_tc", int'(bus.tc), 0);
        check("rst_async_wrap", int'(bus.wrap_cnt), 0);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive(input logic en, input logic load, input logic [1:0] mode,
                         input logic [3:0] load_val, input logic clr_wrap);
        bus.en       = en;
        bus.load     = load;
        bus.mode     = mode;
        bus.load_val = load_val;
        bus.clr_wrap = clr_wrap;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        #12;
        check("reset_count", int'(bus.count), 0);
        check("reset_tc", int'(bus.tc), 0);
        check("reset_wrap", int'(bus.wrap_cnt), 0);
        rst_n = 1'b1;

        // binary up
        drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("up_count[%0d]", i), int'(bus.count), up_cnt[i]);
            check($sformatf("up_tc[%0d]", i), int'(bus.tc), (i == 9) ? 1 : 0);
        end
        check("up_wrap", int'(bus.wrap_cnt), 1);

        // binary down from reset
        pulse_reset();
        drive(1'b1, 1'b0, 2'b01, 4'd0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("down_count[%0d]", i), int'(bus.count), down_cnt[i]);
            check($sformatf("down_tc[%0d]", i), int'(bus.tc), (i == 0 || i == 10) ? 1 : 0);
        end
        check("down_wrap", int'(bus.wrap_cnt), 2);
        drive(1'b1, 1'b1, 2'b01, 4'd12, 1'b0);
        tick();
        check("down_load_clamp", int'(bus.count), 9);
        check("down_load_tc", int'(bus.tc), 0);

        // Gray
        pulse_reset();
        drive(1'b1, 1'b0, 2'b10, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("gray_count[%0d]", i), int'(bus.count), gray_cnt[i]);
            check($sformatf("gray_tc[%0d]", i), int'(bus.tc), 0);
        end
        tick();
        check("gray_wrap_count", int'(bus.count), 0);
        check("gray_wrap_tc", int'(bus.tc), 1);

        // LFSR
        drive(1'b0, 1'b1, 2'b11, 4'd1, 1'b0);
        tick();
        check("lfsr_load1", int'(bus.count), 1);
        drive(1'b1, 1'b0, 2'b11, 4'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("lfsr_count[%0d]", i), int'(bus.count), lfsr_cnt[i]);
            check($sformatf("lfsr_tc[%0d]", i), int'(bus.tc), (i == 14) ? 1 : 0);
        end
        drive(1'b0, 1'b1, 2'b11, 4'd0, 1'b0);
        tick();
        check("lfsr_load0", int'(bus.count), 1);
        check("lfsr_load0_tc", int'(bus.tc), 0);

        // priority and hold
        drive(1'b1, 1'b1, 2'b00, 4'd5, 1'b0);
        tick();
        check("load_over_en", int'(bus.count), 5);
        check("load_over_en_tc", int'(bus.tc), 0);
        drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        tick();
        check("hold_count", int'(bus.count), 5);
        check("hold_tc", int'(bus.tc), 0);

        // LFSR value above MAX_VAL carried into binary up wraps
        drive(1'b0, 1'b1, 2'b11, 4'd13, 1'b0);
        tick();
        check("carry_load", int'(bus.count), 13);
        drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        check("carry_wrap_count", int'(bus.count), 0);
        check("carry_wrap_tc", int'(bus.tc), 1);
        drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        check("tc_one_cycle", int'(bus.tc), 0);

        // wrap_cnt saturation: load 9 then step, 300 times
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 2'b00, 4'd9, 1'b0);
            tick();
            drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
            tick();
            if (i == 254) check("wrap_at_255", int'(bus.wrap_cnt), 255);
        end
        check("wrap_saturated", int'(bus.wrap_cnt), 255);
        drive(1'b0, 1'b1, 2'b00, 4'd9, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b1);
        tick();
        check("clr_with_tc_tc", int'(bus.tc), 1);
        check("clr_with_tc_wrap", int'(bus.wrap_cnt), 0);
        drive(1'b0, 1'b1, 2'b00, 4'd9, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
        tick();
        check("wrap_after_clr", int'(bus.wrap_cnt), 1);

        // reset mid-count, then LFSR steps out of zero
        tick();
        tick();
        check("pre_reset_count", int'(bus.count), 2);
        pulse_reset();
        drive(1'b1, 1'b0, 2'b11, 4'd0, 1'b0);
        tick();
        check("lfsr_escape_count", int'(bus.count), 1);
        check("lfsr_escape_tc", int'(bus.tc), 1);
        check("lfsr_escape_wrap", int'(bus.wrap_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_mode_counter.md
MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits, legal range 2..16.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value for binary and Gray modes (modulus MAX_VAL+1), legal range 1..2**WIDTH-1.
REQ-003 Parameter LFSR_TAPS, default 4'b1100 (x^4+x^3+1), WIDTH-bit feedback tap mask; bit i set = state bit i in XOR feedback.
REQ-004 clk  input  1  single clock, all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance state by one step when high.
REQ-007 mode  input  2  00 binary up, 01 binary down, 10 Gray up, 11 LFSR.
REQ-008 load  input  1  synchronous load of load_val, priority over en.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 clr_wrap  input  1  synchronous clear of wrap_cnt.
REQ-011 count  output  WIDTH  registered counter output.
REQ-012 tc  output  1  registered one-cycle terminal-count/wrap pulse.
REQ-013 wrap_cnt  output  8  registered saturating count of tc pulses.

Function
REQ-014 Internal state s, WIDTH bits; count, tc and wrap_cnt SHALL all be registered and update on the same edge as s.
REQ-015 count SHALL equal s in modes 00, 01, 11 and s^(s>>1) in mode 10, evaluated using next s and the mode sampled on that edge.
REQ-016 Mode 00/10 step: s>=MAX_VAL -> s=0 with tc=1; else s=s+1, tc=0.
REQ-017 Mode 01 step: s==0 -> s=MAX_VAL with tc=1; s>MAX_VAL -> s=MAX_VAL, tc=0; else s=s-1, tc=0.
REQ-018 Mode 11 step: s={s[WIDTH-2:0], XOR of s bits selected by LFSR_TAPS}; tc=1 when new s==1; s==0 on step -> s=1, tc=1 (lock-up escape).
REQ-019 Priority per edge: load > en > hold; hold keeps s and count, tc=0.
REQ-020 Load: s=load_val, tc=0; modes 00/01/10 clamp load_val>MAX_VAL to MAX_VAL; mode 11 replaces load_val==0 with 1.
REQ-021 Mode change takes effect on the edge where it is sampled; s carries over unchanged and is then stepped under the new mode's rule (e.g. LFSR value >MAX_VAL in mode 00 wraps to 0 with tc=1).
REQ-022 wrap_cnt increments by 1 on each edge that sets tc=1, saturates at 255 with no wrap.
REQ-023 clr_wrap high sets wrap_cnt=0 and wins over a simultaneous increment.
REQ-024 Parameter checks: WIDTH<2 or MAX_VAL outside range SHALL fail elaboration.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, force s=0, count=0, tc=0, wrap_cnt=0; exception: mode 11 at deassertion steps from s=0 per REQ-018.
REQ-026 Reset asserted mid-operation SHALL abandon the sequence; first step after release follows REQ-016..018 from s=0.
REQ-027 rst_n release SHALL be synchronised externally; block registers state on the first rising edge with rst_n high.

Verification (WIDTH=4, MAX_VAL=9, LFSR_TAPS=4'b1100 unless stated)
REQ-028 Mode 00, en=1, 12 edges after reset -> count 1..9,0,1,2; tc high only with count=0 (edge 10); wrap_cnt=1.
REQ-029 Mode 01 from reset -> count 9,8,...,0,9 with tc on first 9 and on 0->9 step; load_val=12 -> count=9.
REQ-030 Mode 10 from reset, 4 edges -> count 0001,0011,0010,0110; after s=9 -> count 0000 with tc=1.
REQ-031 Mode 11, load 0001, 15 edges -> 2,4,9,3,6,13,10,5,11,7,15,14,12,8,1; tc only on final edge; load 0 -> count=1.
REQ-032 load and en both high -> count=load_val, tc=0; en=0 -> count holds, tc=0.
REQ-033 300 forced wraps -> wrap_cnt=255; clr_wrap coincident with tc -> wrap_cnt=0; rst_n pulsed low mid-count between edges -> count=0 before next edge.
